// File: rtl/fir_ir_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_ir_filter_if
// Brief    : Sample-in / filtered-out bundle for the IR-channel FIR filter.
// Revision : 1.0  initial release
// ============================================================================
interface fir_ir_filter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 20
);
    logic [DATA_WIDTH-1:0] IR_ADC_Value;
    logic [OUT_WIDTH-1:0]  Out_IR_Filtered;

    modport master (output IR_ADC_Value, input  Out_IR_Filtered);
    modport slave  (input  IR_ADC_Value, output Out_IR_Filtered);
endinterface
`default_nettype wire

// File: rtl/fir_ir_filter.sv
`default_nettype none
// ============================================================================
// Module   : fir_ir_filter
// Brief    : 16-tap direct-form FIR low-pass filter, one sample and one
//            registered result per CLK_Filter rising edge.
// Revision : 1.0  initial release
// ============================================================================
module fir_ir_filter #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 12,
    parameter int NUM_TAPS   = 16,
    parameter int OUT_WIDTH  = 20,
    parameter logic [NUM_TAPS*COEF_WIDTH-1:0] COEFFS = {
        12'd8,   12'd16,  12'd32,  12'd64,  12'd128, 12'd256, 12'd384, 12'd448,
        12'd448, 12'd384, 12'd256, 12'd128, 12'd64,  12'd32,  12'd16,  12'd8
    }
) (
    input  wire             CLK_Filter,
    input  wire             rst_n,
    fir_ir_filter_if.slave  ir_if
);

    localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS);

    logic [DATA_WIDTH-1:0] x_q [NUM_TAPS];
    logic [OUT_WIDTH-1:0]  out_q;
    logic [ACC_WIDTH-1:0]  sum_d;

    // Sum uses the pre-edge delay line, so a new sample reaches the output one edge after it enters x_q[0].
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            sum_d = sum_d
                  + ACC_WIDTH'(COEFFS[k*COEF_WIDTH +: COEF_WIDTH]) * ACC_WIDTH'(x_q[k]);
        end
    end

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                x_q[k] <= '0;
            end
            out_q <= '0;
        end else begin
            x_q[0] <= ir_if.IR_ADC_Value;
            for (int k = 1; k < NUM_TAPS; k++) begin
                x_q[k] <= x_q[k-1];
            end
            out_q <= OUT_WIDTH'(sum_d);
        end
    end

    assign ir_if.Out_IR_Filtered = out_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_ir_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_ir_filter
// Brief    : Scoreboard bench for fir_ir_filter: reference model plus fixed
//            expected sequences for impulse, step, reset and full-scale cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_fir_ir_filter;

    logic clk;
    logic rst_n;

    fir_ir_filter_if bus ();

    fir_ir_filter dut (
        .CLK_Filter (clk),
        .rst_n      (rst_n),
        .ir_if      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          coef [16] = '{8, 16, 32, 64, 128, 256, 384, 448,
                               448, 384, 256, 128, 64, 32, 16, 8};
    int          mx   [16];
    int          sb   [$];
    int          total_cnt = 0;
    int          pass_cnt  = 0;

    task automatic model_clear();
        for (int k = 0; k < 16; k++) mx[k] = 0;
        sb.delete();
    endtask

    // Expected value is the pre-edge weighted history, queued before the edge.
    task automatic drive_sample(input int v);
        int e;
        @(negedge clk);
        bus.IR_ADC_Value = v[7:0];
        e = 0;
        for (int k = 0; k < 16; k++) e += coef[k] * mx[k];
        for (int k = 15; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int e;
        rst_n = 1'b1;
        bus.IR_ADC_Value = 8'h00;
        #1;
        rst_n = 1'b0;
        bus.IR_ADC_Value = 8'hAA;
        #1;
        total_cnt++;
        if (bus.Out_IR_Filtered !== 20'd0)
            $display("FAIL reset_async: got %0d expected 0", bus.Out_IR_Filtered);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus.Out_IR_Filtered !== 20'd0)
            $display("FAIL reset_held: got %0d expected 0", bus.Out_IR_Filtered);
        else pass_cnt++;
        model_clear();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_sample(0);
            e = sb.pop_front();
            total_cnt++;
            if (bus.Out_IR_Filtered !== 20'd0 || e != 0)
                $display("FAIL reset_release[%0d]: got %0d expected 0", i, bus.Out_IR_Filtered);
            else pass_cnt++;
        end
    endtask

    task automatic test_impulse();
        int tbl [18] = '{0, 8, 16, 32, 64, 128, 256, 384, 448, 448,
                         384, 256, 128, 64, 32, 16, 8, 0};
        int e;
        for (int i = 0; i < 18; i++) begin
            drive_sample(i == 0 ? 1 : 0);
            e = sb.pop_front();
            total_cnt++;
            if (bus.Out_IR_Filtered !== 20'(tbl[i]) || e != tbl[i])
                $display("FAIL impulse[%0d]: got %0d expected %0d (model %0d)",
                         i, bus.Out_IR_Filtered, tbl[i], e);
            else pass_cnt++;
        end
    endtask

    task automatic test_step();
        int tbl [4] = '{0, 1600, 4800, 11200};
        int e;
        for (int i = 1; i <= 20; i++) begin
            drive_sample(200);
            e = sb.pop_front();
            total_cnt++;
            if (bus.Out_IR_Filtered !== 20'(e))
                $display("FAIL step_model[%0d]: got %0d expected %0d", i, bus.Out_IR_Filtered, e);
            else pass_cnt++;
            if (i <= 4) begin
                total_cnt++;
                if (bus.Out_IR_Filtered !== 20'(tbl[i-1]))
                    $display("FAIL step_ramp[%0d]: got %0d expected %0d", i, bus.Out_IR_Filtered, tbl[i-1]);
                else pass_cnt++;
            end else if (i >= 17) begin
                total_cnt++;
                if (bus.Out_IR_Filtered !== 20'd534400)
                    $display("FAIL step_settled[%0d]: got %0d expected 534400", i, bus.Out_IR_Filtered);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int tbl [3] = '{0, 800, 2400};
        int e;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.Out_IR_Filtered !== 20'd0)
            $display("FAIL midreset_async: got %0d expected 0", bus.Out_IR_Filtered);
        else pass_cnt++;
        model_clear();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus.Out_IR_Filtered !== 20'd0)
                $display("FAIL midreset_held[%0d]: got %0d expected 0", i, bus.Out_IR_Filtered);
            else pass_cnt++;
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            drive_sample(100);
            e = sb.pop_front();
            total_cnt++;
            if (bus.Out_IR_Filtered !== 20'(e))
                $display("FAIL midreset_model[%0d]: got %0d expected %0d", i, bus.Out_IR_Filtered, e);
            else pass_cnt++;
            if (i <= 3) begin
                total_cnt++;
                if (bus.Out_IR_Filtered !== 20'(tbl[i-1]))
                    $display("FAIL midreset_ramp[%0d]: got %0d expected %0d", i, bus.Out_IR_Filtered, tbl[i-1]);
                else pass_cnt++;
            end else if (i >= 17) begin
                total_cnt++;
                if (bus.Out_IR_Filtered !== 20'd267200)
                    $display("FAIL midreset_settled[%0d]: got %0d expected 267200", i, bus.Out_IR_Filtered);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_full_scale();
        int e;
        for (int i = 1; i <= 20; i++) begin
            drive_sample(255);
            e = sb.pop_front();
            total_cnt++;
            if (bus.Out_IR_Filtered !== 20'(e))
                $display("FAIL fullscale_model[%0d]: got %0d expected %0d", i, bus.Out_IR_Filtered, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.Out_IR_Filtered !== 20'd681360)
            $display("FAIL fullscale_settled: got %0d expected 681360", bus.Out_IR_Filtered);
        else pass_cnt++;
    endtask

    task automatic test_alternating();
        int e;
        for (int i = 0; i < 40; i++) begin
            drive_sample((i % 2 == 0) ? 0 : 255);
            e = sb.pop_front();
            total_cnt++;
            if (bus.Out_IR_Filtered !== 20'(e) || e > 681360)
                $display("FAIL alternating[%0d]: got %0d expected %0d", i, bus.Out_IR_Filtered, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        else pass_cnt++;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_impulse();
        test_step();
        test_reset_mid();
        test_full_scale();
        test_alternating();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
